// File: rtl/x3q16_mem_responder.sv
// x3q16_mem_responder
//   Memory-side responder for the x3q16 core request bus. A one-cycle
//   request strobe is latched with its type/address/data. After the
//   configured number of wait states the read or write is performed
//   against an internal word array, and a one-cycle done pulse is returned.
//   A request seen while a transaction is waiting, or an address outside
//   the array, raises a one-cycle memory_critical pulse.
//
// Parameters
//   DEPTH          number of 16-bit words (valid addresses 0..DEPTH-1)
//   READ_LATENCY   request edge to memory_ready pulse, 1..15 cycles
//   WRITE_LATENCY  request edge to write_complete pulse, 1..15 cycles
//
// Ports
//   clk              system clock, rising edge
//   reset_n          asynchronous active-low reset (array is not cleared)
//   request          one-cycle request strobe
//   request_type     0 = read, 1 = write
//   request_address  word address (full 16 bits range-checked)
//   data_out         write data from the core
//   memory_in        read data, held until the next read completes
//   memory_ready     one-cycle read-done pulse
//   write_complete   one-cycle write-done pulse
//   memory_critical  one-cycle fault pulse
//
// Optional feature (macro X3Q16_MEM_LOADER_EN)
//   Adds load_en/load_addr/load_data: an out-of-band array write port that
//   works independently of reset_n and wins over a same-edge core write.

module x3q16_mem_responder #(
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        request,
  input  logic        request_type,
  input  logic [15:0] request_address,
  input  logic [15:0] data_out,
`ifdef X3Q16_MEM_LOADER_EN
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
`endif
  output logic [15:0] memory_in,
  output logic        memory_ready,
  output logic        write_complete,
  output logic        memory_critical
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [3:0]  RD_WAIT = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  WR_WAIT = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        wc_q, wc_d;
  logic        crit_q, crit_d;

  logic [15:0] mem [DEPTH];

  logic          accept;
  logic [3:0]    loadCount;
  logic          inRange;
  logic [AW-1:0] memIdx;
  logic [15:0]   memRead;

  // The range check uses all 16 address bits; only the low bits index.
  assign inRange = ({1'b0, addr_q} < DEPTH_W);
  assign memIdx  = addr_q[AW-1:0];
  assign memRead = mem[memIdx];

  assign memory_in       = rdata_q;
  assign memory_ready    = ready_q;
  assign write_complete  = wc_q;
  assign memory_critical = crit_q;

  // Next-state and output logic. RESPOND accepts a new request exactly
  // like IDLE so that back-to-back transactions have no bubble.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    wc_d      = 1'b0;
    crit_d    = 1'b0;
    accept    = 1'b0;
    loadCount = request_type ? WR_WAIT : RD_WAIT;

    case (state_q)
      IDLE: begin
        accept = request;
      end
      WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = RESPOND;
        end
        // The in-flight transaction carries on; the stray request is a fault.
        if (request) begin
          crit_d = 1'b1;
        end
      end
      RESPOND: begin
        state_d = IDLE;
        if (type_q) begin
          wc_d = 1'b1;
        end else begin
          ready_d = 1'b1;
          rdata_d = inRange ? memRead : 16'h0000;
        end
        if (!inRange) begin
          crit_d = 1'b1;
        end
        accept = request;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      type_d  = request_type;
      addr_d  = request_address;
      wdata_d = data_out;
      count_d = loadCount;
      state_d = (loadCount == 4'd0) ? RESPOND : WAIT;
    end
  end

  // Control and output registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      type_q  <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      ready_q <= 1'b0;
      wc_q    <= 1'b0;
      crit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      wc_q    <= wc_d;
      crit_q  <= crit_d;
    end
  end

  // Word array: no reset so contents survive reset_n. State is forced to
  // IDLE by reset, which also blocks an aborted write. The loader write is
  // placed last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (state_q == RESPOND && type_q && inRange) begin
      mem[memIdx] <= wdata_q;
    end
`ifdef X3Q16_MEM_LOADER_EN
    if (load_en && ({1'b0, load_addr} < DEPTH_W)) begin
      mem[load_addr[AW-1:0]] <= load_data;
    end
`endif
  end

endmodule

// File: tb/tb_x3q16_mem_responder.sv
// Testbench for x3q16_mem_responder.
//   dutA: default latencies (1/1), table-driven vectors plus reset-release
//         and optional loader sequences.
//   dutB: READ_LATENCY=3, WRITE_LATENCY=4, hand-written latency/abort
//         sequences followed by randomized traffic checked against a
//         transaction-level reference model.

module tb_x3q16_mem_responder;

  localparam int DEPTH  = 256;
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 4;

  logic clk;

  logic        resetNA, reqA, typA;
  logic [15:0] addrA, dataA, memInA;
  logic        readyA, wcA, critA;

  logic        resetNB, reqB, typB;
  logic [15:0] addrB, dataB, memInB;
  logic        readyB, wcB, critB;

`ifdef X3Q16_MEM_LOADER_EN
  logic        loadEnA, loadEnB;
  logic [15:0] loadAddrA, loadDataA, loadAddrB, loadDataB;
`endif

  int compared;
  int failed;

  typedef struct {
    logic        req;
    logic        typ;
    logic [15:0] addr;
    logic [15:0] data;
    logic        eReady;
    logic        eWc;
    logic        eCrit;
    logic [15:0] eMemIn;
  } vec_t;

  vec_t tableA [11];

  // Reference model state for dutB's random phase.
  logic [15:0] modelMem [DEPTH];

  x3q16_mem_responder #(
    .DEPTH(DEPTH), .READ_LATENCY(1), .WRITE_LATENCY(1)
  ) dutA (
    .clk(clk), .reset_n(resetNA), .request(reqA), .request_type(typA),
    .request_address(addrA), .data_out(dataA),
`ifdef X3Q16_MEM_LOADER_EN
    .load_en(loadEnA), .load_addr(loadAddrA), .load_data(loadDataA),
`endif
    .memory_in(memInA), .memory_ready(readyA), .write_complete(wcA),
    .memory_critical(critA)
  );

  x3q16_mem_responder #(
    .DEPTH(DEPTH), .READ_LATENCY(RD_LAT), .WRITE_LATENCY(WR_LAT)
  ) dutB (
    .clk(clk), .reset_n(resetNB), .request(reqB), .request_type(typB),
    .request_address(addrB), .data_out(dataB),
`ifdef X3Q16_MEM_LOADER_EN
    .load_en(loadEnB), .load_addr(loadAddrB), .load_data(loadDataB),
`endif
    .memory_in(memInB), .memory_ready(readyB), .write_complete(wcB),
    .memory_critical(critB)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and report any difference.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Compare all four outputs of one DUT.
  task automatic checkDut(input bit toB, input string tag, input logic eReady,
                          input logic eWc, input logic eCrit,
                          input logic [15:0] eMemIn);
    logic        r, w, c;
    logic [15:0] m;
    r = toB ? readyB : readyA;
    w = toB ? wcB    : wcA;
    c = toB ? critB  : critA;
    m = toB ? memInB : memInA;
    checkOutput($sformatf("%s ready", tag), {15'b0, r}, {15'b0, eReady});
    checkOutput($sformatf("%s wc", tag),    {15'b0, w}, {15'b0, eWc});
    checkOutput($sformatf("%s crit", tag),  {15'b0, c}, {15'b0, eCrit});
    checkOutput($sformatf("%s memIn", tag), m, eMemIn);
  endtask

  // Drive one cycle of inputs from a negedge, advance past one posedge,
  // and return at the following negedge ready for checking.
  task automatic applyStimulus(input bit toB, input logic req, input logic typ,
                               input logic [15:0] addr, input logic [15:0] data);
    if (toB) begin
      reqB = req; typB = typ; addrB = addr; dataB = data;
    end else begin
      reqA = req; typA = typ; addrA = addr; dataA = data;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] bMemIn;
    int          edgeNum;
    bit          inflight;
    int          doneEdge;
    logic        pType;
    logic [15:0] pAddr, pData;
    logic        eReady, eWc, eCrit;
    logic        rq, ty;
    logic [15:0] ad, dt;

    compared = 0;
    failed   = 0;

    // Per-cycle vectors for dutA: inputs at an edge, outputs after it.
    tableA[0]  = '{1'b1, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000};
    tableA[1]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000};
    tableA[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    tableA[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hBEEF};
    tableA[4]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF};
    tableA[5]  = '{1'b1, 1'b1, 16'h0100, 16'hDEAD, 1'b1, 1'b0, 1'b1, 16'h0000};
    tableA[6]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000};
    tableA[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1234};
    tableA[8]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234};
    tableA[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hBEEF};
    tableA[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF};

    resetNA = 1'b0; reqA = 1'b0; typA = 1'b0; addrA = '0; dataA = '0;
    resetNB = 1'b0; reqB = 1'b0; typB = 1'b0; addrB = '0; dataB = '0;
`ifdef X3Q16_MEM_LOADER_EN
    loadEnA = 1'b0; loadAddrA = '0; loadDataA = '0;
    loadEnB = 1'b0; loadAddrB = '0; loadDataB = '0;
`endif

    // Outputs under asynchronous reset, before any clock edge.
    #1;
    checkDut(1'b0, "A reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    checkDut(1'b1, "B reset", 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    @(negedge clk);

    // dutA table: release reset and immediately start issuing requests.
    resetNA = 1'b1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, tableA[i].req, tableA[i].typ, tableA[i].addr, tableA[i].data);
      checkDut(1'b0, $sformatf("A vec%0d", i), tableA[i].eReady, tableA[i].eWc,
               tableA[i].eCrit, tableA[i].eMemIn);
    end

    // Reset clears outputs but keeps the array; a read on the first edge
    // after release must be served.
    resetNA = 1'b0;
    #1;
    checkDut(1'b0, "A rst again", 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    resetNA = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    checkDut(1'b0, "A rel req", 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkDut(1'b0, "A rel rd", 1'b1, 1'b0, 1'b0, 16'h1234);

`ifdef X3Q16_MEM_LOADER_EN
    // Loader under reset, out-of-range load ignored, then collision.
    resetNA = 1'b0;
    loadEnA = 1'b1; loadAddrA = 16'h0003; loadDataA = 16'h0007;
    @(negedge clk);
    loadAddrA = 16'h0103; loadDataA = 16'hFFFF;
    @(negedge clk);
    loadEnA = 1'b0;
    resetNA = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    checkDut(1'b0, "A ld req", 1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkDut(1'b0, "A ld rd", 1'b1, 1'b0, 1'b0, 16'h0007);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0004, 16'h1111);
    loadEnA = 1'b1; loadAddrA = 16'h0004; loadDataA = 16'h2222;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    loadEnA = 1'b0;
    checkDut(1'b0, "A ld coll wr", 1'b0, 1'b1, 1'b0, 16'h0007);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkDut(1'b0, "A ld coll rd", 1'b1, 1'b0, 1'b0, 16'h2222);
`endif

    // dutB: write latency exactly four cycles.
    resetNB = 1'b1;
    bMemIn  = 16'h0000;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0005, 16'h7777);
    for (int k = 1; k <= WR_LAT; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      checkDut(1'b1, $sformatf("B wr5 k%0d", k), 1'b0, (k == WR_LAT), 1'b0, bMemIn);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0020, 16'h5555);
    for (int k = 1; k <= WR_LAT; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      checkDut(1'b1, $sformatf("B wr20 k%0d", k), 1'b0, (k == WR_LAT), 1'b0, bMemIn);
    end

    // Read latency three with a stray request while waiting.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000);
    checkDut(1'b1, "B rd5 e0", 1'b0, 1'b0, 1'b0, bMemIn);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0009, 16'hFFFF);
    checkDut(1'b1, "B rd5 stray", 1'b0, 1'b0, 1'b1, bMemIn);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkDut(1'b1, "B rd5 e2", 1'b0, 1'b0, 1'b0, bMemIn);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    bMemIn = 16'h7777;
    checkDut(1'b1, "B rd5 done", 1'b1, 1'b0, 1'b0, bMemIn);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkDut(1'b1, "B rd5 after", 1'b0, 1'b0, 1'b0, bMemIn);

    // Reset one cycle into a write aborts it.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0020, 16'hAAAA);
    resetNB = 1'b0;
    reqB    = 1'b0;
    bMemIn  = 16'h0000;
    #1;
    checkDut(1'b1, "B abort rst", 1'b0, 1'b0, 1'b0, bMemIn);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkDut(1'b1, $sformatf("B abort hold%0d", k), 1'b0, 1'b0, 1'b0, bMemIn);
    end
    resetNB = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    for (int k = 1; k <= RD_LAT; k++) begin
      if (k == RD_LAT) bMemIn = 16'h5555;
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      checkDut(1'b1, $sformatf("B abort rd k%0d", k), (k == RD_LAT), 1'b0, 1'b0, bMemIn);
    end

    // Fill every word of dutB with a known pattern for the random phase.
    for (int i = 0; i < DEPTH; i++) begin
      modelMem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      applyStimulus(1'b1, 1'b1, 1'b1, 16'(i), modelMem[i]);
      for (int k = 1; k <= WR_LAT; k++) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      checkOutput($sformatf("B fill%0d wc", i), {15'b0, wcB}, 16'h0001);
    end

    // Random traffic. The model schedules each accepted request to finish
    // at its issue edge plus latency; requests while busy are faults.
    inflight = 1'b0;
    doneEdge = 0;
    pType    = 1'b0;
    pAddr    = '0;
    pData    = '0;
    for (edgeNum = 0; edgeNum < 600; edgeNum++) begin
      rq = ($urandom_range(0, 1) == 0);
      ty = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ad = 16'($urandom) | 16'h0100;
      else ad = 16'($urandom_range(0, DEPTH - 1));
      dt = 16'($urandom);
      applyStimulus(1'b1, rq, ty, ad, dt);

      eReady = 1'b0;
      eWc    = 1'b0;
      eCrit  = 1'b0;
      if (inflight && doneEdge == edgeNum) begin
        inflight = 1'b0;
        if (pType) begin
          eWc = 1'b1;
          if (pAddr < DEPTH) modelMem[pAddr[7:0]] = pData;
        end else begin
          eReady = 1'b1;
          bMemIn = (pAddr < DEPTH) ? modelMem[pAddr[7:0]] : 16'h0000;
        end
        if (pAddr >= DEPTH) eCrit = 1'b1;
      end
      if (rq) begin
        if (!inflight) begin
          inflight = 1'b1;
          doneEdge = edgeNum + (ty ? WR_LAT : RD_LAT);
          pType    = ty;
          pAddr    = ad;
          pData    = dt;
        end else begin
          eCrit = 1'b1;
        end
      end
      checkDut(1'b1, $sformatf("B rand%0d", edgeNum), eReady, eWc, eCrit, bMemIn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/x3q16_mem_responder.md
Name: x3q16_mem_responder

Overview:
- Memory-side responder for the x3q16 core's request bus.
- Accepts single-cycle read/write request pulses from the core and serves them from an internal word array, with configurable wait states.
- Returns memory_in/memory_ready for reads and write_complete for writes.
- Drives memory_critical on protocol or addressing faults; this feeds the core's status flag.

Parameters:
- DEPTH, 256: number of 16-bit words; valid addresses 0..DEPTH-1.
- READ_LATENCY, 1: cycles from request edge to memory_ready pulse; legal range 1..15.
- WRITE_LATENCY, 1: cycles from request edge to write_complete pulse; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- request  in  1  one-cycle request strobe from the core.
- request_type  in  1  0 = read, 1 = write; sampled with request.
- request_address  in  16  word address; sampled with request.
- data_out  in  16  write data from the core; sampled with request.
- memory_in  out  16  read data; valid when memory_ready=1, held until the next read completes.
- memory_ready  out  1  one-cycle read-done pulse.
- write_complete  out  1  one-cycle write-done pulse.
- memory_critical  out  1  one-cycle fault pulse.

Behaviour:
- Reset (reset_n=0, async):
  - memory_in=0, memory_ready=0, write_complete=0, memory_critical=0.
  - State=IDLE, wait counter=0.
  - Word array is NOT cleared; contents are preserved across reset.
- The core raises request in its first cycle after reset release. The responder must accept a request in the first clock after reset_n deasserts.
- IDLE:
  - On a clock edge with request=1, latch address/type/data and load counter with the relevant latency minus 1.
  - If that value is 0, go to RESPOND; otherwise go to WAIT.
- WAIT: decrement counter each edge; at 0 go to RESPOND.
- RESPOND (one cycle):
  - Read: memory_in <= mem[addr]; memory_ready pulses.
  - Write: mem[addr] <= data at this edge; write_complete pulses.
  - Return to IDLE.
- Latency:
  - Request sampled at edge N; the done pulse is high for the cycle after edge N+LATENCY.
  - Default (1): the pulse is visible in the cycle immediately following the request cycle.
- A request arriving in RESPOND's own cycle (back-to-back) is accepted as an IDLE request; zero bubble.
- Request=1 during WAIT: ignored. The in-flight transaction is unaffected; memory_critical pulses the next cycle.
- Address >= DEPTH:
  - Read returns 16'h0000 with memory_ready.
  - Write is discarded but write_complete still pulses.
  - memory_critical pulses in the same cycle as the done pulse.
- memory_ready and write_complete are never high simultaneously.
- Only address bits [clog2(DEPTH)-1:0] index the array; range check uses the full 16 bits.
- memory_in changes only on read completion.
- Reset asserted mid-WAIT aborts the transaction: no done pulse, no array write.

Optional Feature:
- Macro X3Q16_MEM_LOADER_EN.
- Enabled, adds three ports:
  - load_en  in  1
  - load_addr  in  16
  - load_data  in  16
- Enabled behaviour:
  - When load_en=1 at a clock edge and load_addr<DEPTH, mem[load_addr] <= load_data.
  - Used for program loading while the core is held in reset; works regardless of reset_n.
  - If a core write in RESPOND hits the same address on the same edge, the loader wins.
  - load_en with an out-of-range address is ignored; no fault is raised.
- Disabled: the ports do not exist; the array is writable only via core requests.

Test Plan:
- Reset release with request=1, addr=0x0000, type=0, mem[0] preloaded 0x1234 -> memory_ready pulse 1 cycle later; memory_in=0x1234.
- Write addr=0x0010, data=0xBEEF, then read 0x0010 next cycle -> write_complete pulse, then memory_ready with memory_in=0xBEEF; no bubble between requests.
- READ_LATENCY=3, read addr=0x0005 -> memory_ready exactly 3 cycles after the request edge; an extra request during WAIT -> memory_critical pulse, original data still returned.
- DEPTH=256, read 0x0100 -> memory_ready with memory_in=0x0000 and memory_critical high in the same cycle. Write 0x0100 -> write_complete + memory_critical, mem[0x00] unchanged.
- reset_n asserted 1 cycle into a WRITE_LATENCY=4 write of 0xAAAA to 0x0020 (old 0x5555) -> no write_complete; mem[0x20] still 0x5555; outputs 0.
- X3Q16_MEM_LOADER_EN defined: load 0x0007 to addr 3 with reset_n=0, release reset, read 3 -> memory_in=0x0007.
